// File: rtl/simon_tone_sequencer_pkg.sv
// Shared definitions for the Simon tone sequencer: colour codes, sizing
// constants and the length-clamping helper.
package simon_tone_sequencer_pkg;

  localparam int unsigned COLOUR_W  = 2;
  localparam int unsigned LEN_W     = 6;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned MAX_STEPS = 32;

  typedef enum logic [COLOUR_W-1:0] {
    GREEN  = 2'd0,
    RED    = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } colour_t;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_STEPS)) ? LEN_W'(MAX_STEPS) : len;
  endfunction

endpackage

// File: rtl/simon_tone_sequencer_if.sv
// Control, sequence-memory and tone-generator signals of the sequencer.
// master = game-control side, slave = the sequencer itself.
interface simon_tone_sequencer_if;
  import simon_tone_sequencer_pkg::*;

  logic                 start;
  logic                 abort;
  logic [LEN_W-1:0]     length;
  logic [ADDR_W-1:0]    seq_addr;
  colour_t              seq_data;
  logic                 tone_enable;
  colour_t              tone_select;
  logic                 busy;
  logic                 done;

  modport master (
    output start, abort, length, seq_data,
    input  seq_addr, tone_enable, tone_select, busy, done
  );

  modport slave (
    input  start, abort, length, seq_data,
    output seq_addr, tone_enable, tone_select, busy, done
  );

endinterface

// File: rtl/simon_tone_sequencer.sv
// Plays a stored Simon colour sequence: per step one fetch cycle, a fixed
// tone on-time and a silent gap; pulses done when the sequence completes.
module simon_tone_sequencer
  import simon_tone_sequencer_pkg::*;
#(
  parameter int unsigned TONE_CYCLES = 42_000_000,
  parameter int unsigned GAP_CYCLES  = 5_000_000,
  parameter int unsigned TIMER_W     = 26
) (
  input  logic                   clk,
  input  logic                   reset,
  simon_tone_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_TONE  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam logic [TIMER_W-1:0] TONE_LOAD = TIMER_W'(TONE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);

  logic [1:0]         state;
  logic [TIMER_W-1:0] timer;
  logic [ADDR_W-1:0]  idx;
  logic [ADDR_W-1:0]  last_idx;
  logic [ADDR_W-1:0]  addr_q;
  colour_t            sel_q;
  logic               en_q;
  logic               busy_q;
  logic               done_q;
  logic [LEN_W-1:0]   len_clamped;

  assign len_clamped = clamp_len(bus.length);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      timer    <= '0;
      idx      <= '0;
      last_idx <= '0;
      addr_q   <= '0;
      sel_q    <= GREEN;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        state  <= S_IDLE;
        timer  <= '0;
        idx    <= '0;
        addr_q <= '0;
        en_q   <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              if (len_clamped == '0) begin
                done_q <= 1'b1;
              end else begin
                // Store length-1 so the last-step test is a plain index compare.
                last_idx <= ADDR_W'(len_clamped - LEN_W'(1));
                idx      <= '0;
                addr_q   <= '0;
                busy_q   <= 1'b1;
                state    <= S_FETCH;
              end
            end
          end
          S_FETCH: begin
            sel_q <= bus.seq_data;
            timer <= TONE_LOAD;
            en_q  <= 1'b1;
            state <= S_TONE;
          end
          S_TONE: begin
            if (timer == '0) begin
              timer <= GAP_LOAD;
              en_q  <= 1'b0;
              state <= S_GAP;
            end else begin
              timer <= timer - TIMER_W'(1);
            end
          end
          S_GAP: begin
            if (timer == '0) begin
              if (idx == last_idx) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                state  <= S_IDLE;
              end else begin
                idx    <= idx + ADDR_W'(1);
                addr_q <= idx + ADDR_W'(1);
                state  <= S_FETCH;
              end
            end else begin
              timer <= timer - TIMER_W'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.seq_addr    = addr_q;
  assign bus.tone_select = sel_q;
  assign bus.tone_enable = en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_simon_tone_sequencer.sv
// Scoreboard bench for simon_tone_sequencer: expected tone pulses and done
// pulses are queued at start time and matched as the outputs appear.
module tb_simon_tone_sequencer;
  import simon_tone_sequencer_pkg::*;

  localparam int T = 4;
  localparam int G = 2;
  localparam int P = 1 + T + G;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  simon_tone_sequencer_if bus ();

  simon_tone_sequencer #(
    .TONE_CYCLES(T),
    .GAP_CYCLES (G),
    .TIMER_W    (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  colour_t mem [32];
  assign bus.seq_data = mem[bus.seq_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit      is_done;
    int      cyc;
    int      addr;
    colour_t col;
    int      width;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor: pops one entry per tone rise and per done pulse.
  exp_t    e_mon;
  logic    prev_en = 1'b0;
  int      width = 0;
  int      exp_width = 0;
  colour_t exp_col = GREEN;

  always @(negedge clk) begin
    if (bus.tone_enable && !prev_en) begin
      width = 1;
      if (q.size() == 0) begin
        check("unexpected_tone", 1, 0);
      end else begin
        e_mon = q.pop_front();
        check("tone_kind", 32'(e_mon.is_done), 0);
        check("tone_cyc", cyc, e_mon.cyc);
        check("tone_addr", 32'(bus.seq_addr), e_mon.addr);
        check("tone_sel", 32'(bus.tone_select), 32'(e_mon.col));
        exp_width = e_mon.width;
        exp_col   = e_mon.col;
      end
    end else if (bus.tone_enable) begin
      width++;
    end else if (prev_en) begin
      check("tone_width", width, exp_width);
      check("sel_hold", 32'(bus.tone_select), 32'(exp_col));
    end
    if (bus.done) begin
      check("done_busy", 32'(bus.busy), 0);
      check("done_en", 32'(bus.tone_enable), 0);
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e_mon = q.pop_front();
        check("done_kind", 32'(e_mon.is_done), 1);
        check("done_cyc", cyc, e_mon.cyc);
      end
    end
    prev_en = bus.tone_enable;
  end

  task automatic push_run(input int k, input int len, input int n_push,
                          input bit push_done, input int last_width);
    exp_t e;
    int steps;
    steps = (len > 32) ? 32 : len;
    for (int n = 0; n < n_push; n++) begin
      e.is_done = 1'b0;
      e.cyc     = k + n * P + 1;
      e.addr    = n;
      e.col     = mem[n];
      e.width   = (n == n_push - 1) ? last_width : T;
      q.push_back(e);
    end
    if (push_done) begin
      e.is_done = 1'b1;
      e.cyc     = k + steps * P;
      e.addr    = 0;
      e.col     = GREEN;
      e.width   = 0;
      q.push_back(e);
    end
  endtask

  task automatic play(input int len, input int n_push, input bit push_done,
                      input int last_width, output int k);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.length = 6'(len);
    k = cyc + 1;
    push_run(k, len, n_push, push_done, last_width);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, q.size(), 0);
    @(negedge clk);
    check({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  int k;

  initial begin
    mem[0] = BLUE;
    mem[1] = RED;
    mem[2] = YELLOW;
    for (int i = 3; i < 32; i++) mem[i] = colour_t'($urandom_range(0, 3));
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.length = '0;
    reset      = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_en", 32'(bus.tone_enable), 0);
    check("rst_addr", 32'(bus.seq_addr), 0);
    check("rst_sel", 32'(bus.tone_select), 32'(GREEN));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Three-step run
    play(3, 3, 1'b1, T, k);
    check("run3_busy", 32'(bus.busy), 1);
    wait_drain("run3_drain", 100);

    // Zero length: done only
    play(0, 0, 1'b1, T, k);
    check("len0_busy", 32'(bus.busy), 0);
    wait_drain("len0_drain", 10);

    // Length clamped to 32
    play(40, 32, 1'b1, T, k);
    wait_drain("len40_drain", 300);

    // Start during step 1 is ignored
    play(3, 3, 1'b1, T, k);
    wait_until(k + P + 2);
    bus.start  = 1'b1;
    bus.length = 6'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain("restart_drain", 100);

    // Abort on the second TONE cycle of step 1
    play(3, 2, 1'b0, 2, k);
    wait_until(k + P + 2);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_en", 32'(bus.tone_enable), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_addr", 32'(bus.seq_addr), 0);
    repeat (30) @(negedge clk);
    check("abort_quiet", q.size(), 0);
    play(1, 1, 1'b1, T, k);
    wait_drain("post_abort_drain", 50);

    // Asynchronous reset in the middle of a GAP
    play(2, 1, 1'b0, T, k);
    wait_until(k + T + 1);
    check("pre_rst_busy", 32'(bus.busy), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_en", 32'(bus.tone_enable), 0);
    check("arst_done", 32'(bus.done), 0);
    check("arst_addr", 32'(bus.seq_addr), 0);
    check("arst_sel", 32'(bus.tone_select), 32'(GREEN));
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("arst_quiet", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
